// File: rtl/axi4_sram_slave_if.sv
// AXI4 read/write channel bundle between a master and axi4_sram_slave.
interface axi4_sram_slave_if;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;

    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic [3:0]  rid;

    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;

    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;

    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic [3:0]  bid;

    modport master (
        output arvalid, araddr, arid, arlen, arsize, arburst,
        output rready,
        output awvalid, awaddr, awid, awlen, awsize, awburst,
        output wvalid, wdata, wstrb, wlast,
        output bready,
        input  arready, rvalid, rdata, rresp, rlast, rid,
        input  awready, wready, bvalid, bresp, bid
    );

    modport slave (
        input  arvalid, araddr, arid, arlen, arsize, arburst,
        input  rready,
        input  awvalid, awaddr, awid, awlen, awsize, awburst,
        input  wvalid, wdata, wstrb, wlast,
        input  bready,
        output arready, rvalid, rdata, rresp, rlast, rid,
        output awready, wready, bvalid, bresp, bid
    );
endinterface

// File: rtl/axi4_sram_slave.sv
// AXI4 slave on a word SRAM, one transaction at a time; first R beat RD_LAT cycles after AR, B the cycle after the last W.
// R/B held until rready/bready; define AXI_SLV_RAND_WAIT_EN for LFSR-driven random wait states.
module axi4_sram_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          RD_LAT      = 1
) (
    input  logic             clk,
    input  logic             rst,
    axi4_sram_slave_if.slave bus
);
    localparam int          AW   = $clog2(DEPTH_WORDS);
    localparam int          OW   = AW + 2;
    localparam int          WW   = $clog2(RD_LAT + 4) + 1;
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

    typedef enum logic [2:0] {IDLE, R_WAIT, R_BEAT, W_DATA, W_RESP} state_t;

    state_t        state;
    logic [31:0]   mem [DEPTH_WORDS];
    logic [OW-1:0] off;
    logic [2:0]    size;
    logic [1:0]    burst;
    logic [1:0]    err;
    logic [7:0]    cnt;
    logic [WW-1:0] wait_cnt;
    logic          wstall;

    function automatic logic [1:0] classify(input logic [31:0] addr, input logic [2:0] sz,
                                            input logic [1:0] bt);
        logic [32:0] diff;
        diff = {1'b0, addr} - {1'b0, BASE_ADDR};
        if (diff[32] || diff >= SPAN) return 2'b11;
        if (sz > 3'd2 || bt[1]) return 2'b10;
        return 2'b00;
    endfunction

    // Byte offset from BASE_ADDR, kept at array width so INCR wraps modulo the array.
    function automatic logic [OW-1:0] step(input logic [OW-1:0] o, input logic [2:0] sz,
                                           input logic [1:0] bt);
        logic [OW-1:0] inc;
        case (sz)
            3'd0:    inc = OW'(1);
            3'd1:    inc = OW'(2);
            default: inc = OW'(4);
        endcase
        return (bt == 2'b01) ? o + inc : o;
    endfunction

    logic [1:0] rnd_wait;
    logic       rnd_stall;
`ifdef AXI_SLV_RAND_WAIT_EN
    logic [7:0] lfsr;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr <= 8'hA5;
        else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
    assign rnd_wait  = lfsr[1:0];
    assign rnd_stall = lfsr[2];
`else
    assign rnd_wait  = 2'b00;
    assign rnd_stall = 1'b0;
`endif

    assign bus.arready = (state == IDLE) && bus.arvalid;
    assign bus.awready = (state == IDLE) && bus.awvalid && bus.wvalid && !bus.arvalid;
    assign bus.wready  = bus.awready || (state == W_DATA && !wstall);

    logic [1:0]    ar_err, aw_err, w_err_src, w_resp;
    logic [OW-1:0] ar_off, aw_off, w_off, nxt_off;
    logic [WW-1:0] rd_first;
    logic          w_hs, w_cnt0, w_last_beat, w_mism;

    assign ar_err      = classify(bus.araddr, bus.arsize, bus.arburst);
    assign aw_err      = classify(bus.awaddr, bus.awsize, bus.awburst);
    assign ar_off      = OW'(bus.araddr - BASE_ADDR);
    assign aw_off      = OW'(bus.awaddr - BASE_ADDR);
    assign nxt_off     = step(off, size, burst);
    assign rd_first    = WW'(RD_LAT) + WW'(rnd_wait);

    // The first W beat is taken in IDLE alongside AW, so its context comes from the AW bus.
    assign w_hs        = bus.wvalid && bus.wready;
    assign w_off       = (state == IDLE) ? aw_off : off;
    assign w_err_src   = (state == IDLE) ? aw_err : err;
    assign w_cnt0      = (state == IDLE) ? (bus.awlen == 8'd0) : (cnt == 8'd0);
    assign w_last_beat = bus.wlast || w_cnt0;
    assign w_mism      = bus.wlast != w_cnt0;
    assign w_resp      = (w_err_src != 2'b00) ? w_err_src : (w_mism ? 2'b10 : 2'b00);

    always_ff @(posedge clk) begin
        if (w_hs && w_err_src == 2'b00) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.wstrb[i]) mem[w_off[OW-1:2]][8*i +: 8] <= bus.wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            off        <= '0;
            size       <= '0;
            burst      <= '0;
            err        <= '0;
            cnt        <= '0;
            wait_cnt   <= '0;
            wstall     <= 1'b0;
            bus.rvalid <= 1'b0;
            bus.rdata  <= '0;
            bus.rresp  <= '0;
            bus.rlast  <= 1'b0;
            bus.rid    <= '0;
            bus.bvalid <= 1'b0;
            bus.bresp  <= '0;
            bus.bid    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.arvalid) begin
                        off       <= ar_off;
                        size      <= bus.arsize;
                        burst     <= bus.arburst;
                        err       <= ar_err;
                        cnt       <= bus.arlen;
                        bus.rid   <= bus.arid;
                        bus.rresp <= ar_err;
                        bus.rlast <= (bus.arlen == 8'd0);
                        bus.rdata <= (ar_err == 2'b00) ? mem[ar_off[OW-1:2]] : 32'h0;
                        if (rd_first == '0) begin
                            state      <= R_BEAT;
                            bus.rvalid <= 1'b1;
                        end else begin
                            state    <= R_WAIT;
                            wait_cnt <= rd_first - WW'(1);
                        end
                    end else if (bus.awready) begin
                        off     <= step(aw_off, bus.awsize, bus.awburst);
                        size    <= bus.awsize;
                        burst   <= bus.awburst;
                        err     <= aw_err;
                        bus.bid <= bus.awid;
                        if (w_last_beat) begin
                            state     <= W_RESP;
                            bus.bresp <= w_resp;
                            if (rnd_wait == 2'b00) bus.bvalid <= 1'b1;
                            else                   wait_cnt   <= WW'(rnd_wait) - WW'(1);
                        end else begin
                            state  <= W_DATA;
                            cnt    <= bus.awlen - 8'd1;
                            wstall <= rnd_stall;
                        end
                    end
                end
                R_WAIT: begin
                    if (wait_cnt == '0) begin
                        state      <= R_BEAT;
                        bus.rvalid <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - WW'(1);
                    end
                end
                R_BEAT: begin
                    if (bus.rready) begin
                        if (cnt == 8'd0) begin
                            state      <= IDLE;
                            bus.rvalid <= 1'b0;
                            bus.rlast  <= 1'b0;
                        end else begin
                            cnt       <= cnt - 8'd1;
                            off       <= nxt_off;
                            bus.rlast <= (cnt == 8'd1);
                            bus.rdata <= (err == 2'b00) ? mem[nxt_off[OW-1:2]] : 32'h0;
                            if (rnd_wait != 2'b00) begin
                                state      <= R_WAIT;
                                bus.rvalid <= 1'b0;
                                wait_cnt   <= WW'(rnd_wait) - WW'(1);
                            end
                        end
                    end
                end
                W_DATA: begin
                    if (wstall) begin
                        wstall <= 1'b0;
                    end else if (bus.wvalid) begin
                        off <= nxt_off;
                        if (w_last_beat) begin
                            state     <= W_RESP;
                            bus.bresp <= w_resp;
                            if (rnd_wait == 2'b00) bus.bvalid <= 1'b1;
                            else                   wait_cnt   <= WW'(rnd_wait) - WW'(1);
                        end else begin
                            cnt    <= cnt - 8'd1;
                            wstall <= rnd_stall;
                        end
                    end
                end
                W_RESP: begin
                    if (!bus.bvalid) begin
                        if (wait_cnt == '0) bus.bvalid <= 1'b1;
                        else                wait_cnt   <= wait_cnt - WW'(1);
                    end else if (bus.bready) begin
                        bus.bvalid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi4_sram_slave.sv
// Directed + randomized bench for axi4_sram_slave against a flat word-array model.
module tb_axi4_sram_slave;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 1024;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi4_sram_slave_if bus ();

    axi4_sram_slave #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .RD_LAT(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model [DEPTH];
    logic [31:0] wd [256];
    logic [3:0]  ws [256];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_err(input logic [31:0] a, input logic [2:0] sz,
                                           input logic [1:0] bt);
        longint unsigned aa, lo, hi;
        aa = a; lo = BASE; hi = lo + 4 * DEPTH;
        if (aa < lo || aa >= hi) return 2'd3;
        if (sz > 3'd2 || bt >= 2'd2) return 2'd2;
        return 2'd0;
    endfunction

    function automatic int word_of(input longint unsigned o);
        return int'((o >> 2) % DEPTH);
    endfunction

    function automatic longint unsigned next_off(input longint unsigned o, input logic [2:0] sz,
                                                 input logic [1:0] bt);
        if (bt == 2'd1) return (o + (longint'(1) << sz)) % (4 * DEPTH);
        return o;
    endfunction

    // mode: 0 rready always high, 1 random rready gaps, 2 rready low 2 cycles before beat 2
    task automatic axi_read(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                            input logic [2:0] sz, input logic [1:0] bt, input int mode,
                            input string tag, output int lat, output logic [31:0] last_d);
        logic [1:0]      e;
        logic [31:0]     rel, expd, snap;
        longint unsigned o;
        int              n, hold;
        e = exp_err(a, sz, bt);
        rel = a - BASE;
        o = rel;
        lat = -1;
        last_d = 32'h0;
        @(negedge clk);
        bus.arvalid = 1'b1; bus.araddr = a; bus.arid = id; bus.arlen = len;
        bus.arsize = sz; bus.arburst = bt; bus.rready = 1'b0;
        #1; n = 0;
        while (!bus.arready && n < 100) begin @(negedge clk); #1; n++; end
        chk({tag, "_arready"}, 32'(bus.arready), 32'd1);
        @(negedge clk);
        bus.arvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            expd = (e == 2'd0) ? model[word_of(o)] : 32'h0;
            hold = (mode == 2 && b == 2) ? 2 : ((mode == 1) ? int'($urandom_range(0, 2)) : 0);
            #1; n = 0;
            while (!bus.rvalid && n < 100) begin @(negedge clk); #1; n++; end
            if (b == 0) lat = n;
            chk({tag, "_rvalid"}, 32'(bus.rvalid), 32'd1);
            snap = bus.rdata;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk); #1;
                chk({tag, "_hold_rvalid"}, 32'(bus.rvalid), 32'd1);
                chk({tag, "_hold_rdata"}, bus.rdata, snap);
            end
            bus.rready = 1'b1;
            chk({tag, "_rdata"}, bus.rdata, expd);
            chk({tag, "_rresp"}, 32'(bus.rresp), 32'(e));
            chk({tag, "_rlast"}, 32'(bus.rlast), 32'(b == int'(len)));
            chk({tag, "_rid"}, 32'(bus.rid), 32'(id));
            last_d = bus.rdata;
            @(negedge clk);
            bus.rready = 1'b0;
            o = next_off(o, sz, bt);
        end
    endtask

    // Sends nb W beats from wd/ws with wlast on the final one; nb may be shorter than len+1.
    task automatic axi_write(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                             input logic [2:0] sz, input logic [1:0] bt, input int nb,
                             input int gaps, input string tag, output int blat);
        logic [1:0]      e, eb;
        logic [31:0]     rel;
        longint unsigned o;
        int              n, w;
        e = exp_err(a, sz, bt);
        eb = (e != 2'd0) ? e : ((nb != int'(len) + 1) ? 2'd2 : 2'd0);
        @(negedge clk);
        bus.awvalid = 1'b1; bus.awaddr = a; bus.awid = id; bus.awlen = len;
        bus.awsize = sz; bus.awburst = bt; bus.bready = 1'b0;
        bus.wvalid = 1'b1; bus.wdata = wd[0]; bus.wstrb = ws[0]; bus.wlast = (nb == 1);
        #1; n = 0;
        while (!bus.awready && n < 100) begin @(negedge clk); #1; n++; end
        chk({tag, "_awready"}, 32'(bus.awready), 32'd1);
        chk({tag, "_aw_w_same_cycle"}, 32'(bus.wready), 32'd1);
        for (int b = 1; b < nb; b++) begin
            @(negedge clk);
            bus.awvalid = 1'b0; bus.wvalid = 1'b0;
            if (gaps != 0) repeat ($urandom_range(0, 1)) @(negedge clk);
            bus.wvalid = 1'b1; bus.wdata = wd[b]; bus.wstrb = ws[b]; bus.wlast = (b == nb - 1);
            #1; n = 0;
            while (!bus.wready && n < 100) begin @(negedge clk); #1; n++; end
            chk({tag, "_wready"}, 32'(bus.wready), 32'd1);
        end
        @(negedge clk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.wlast = 1'b0;
        #1; n = 0;
        while (!bus.bvalid && n < 100) begin @(negedge clk); #1; n++; end
        blat = n;
        chk({tag, "_bvalid"}, 32'(bus.bvalid), 32'd1);
        chk({tag, "_bresp"}, 32'(bus.bresp), 32'(eb));
        chk({tag, "_bid"}, 32'(bus.bid), 32'(id));
        bus.bready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;
        if (e == 2'd0) begin
            rel = a - BASE;
            o = rel;
            for (int b = 0; b < nb; b++) begin
                w = word_of(o);
                for (int i = 0; i < 4; i++) if (ws[b][i]) model[w][8*i +: 8] = wd[b][8*i +: 8];
                o = next_off(o, sz, bt);
            end
        end
    endtask

    int          lat, blat, n, nb;
    logic [31:0] d, a;
    logic [7:0]  len;
    logic [2:0]  sz;
    logic [1:0]  bt;

    initial begin
        rst = 1'b1;
        bus.arvalid = 0; bus.araddr = 0; bus.arid = 0; bus.arlen = 0; bus.arsize = 0; bus.arburst = 0;
        bus.rready = 0; bus.bready = 0;
        bus.awvalid = 0; bus.awaddr = 0; bus.awid = 0; bus.awlen = 0; bus.awsize = 0; bus.awburst = 0;
        bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0;
        #1;
        chk("rst_arready", 32'(bus.arready), 32'd0);
        chk("rst_awready", 32'(bus.awready), 32'd0);
        chk("rst_wready", 32'(bus.wready), 32'd0);
        chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        chk("rst_rresp", 32'(bus.rresp), 32'd0);
        chk("rst_rlast", 32'(bus.rlast), 32'd0);
        chk("rst_rid", 32'(bus.rid), 32'd0);
        chk("rst_bvalid", 32'(bus.bvalid), 32'd0);
        chk("rst_bresp", 32'(bus.bresp), 32'd0);
        chk("rst_bid", 32'(bus.bid), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Fill the whole array with 256-beat INCR bursts so every word has a known value.
        for (int k = 0; k < 4; k++) begin
            for (int b = 0; b < 256; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
            axi_write(BASE + 32'(k * 1024), 4'(k), 8'd255, 3'd2, 2'd1, 256, 0, "fill", blat);
        end

        wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF;
        axi_write(BASE + 32'h10, 4'd5, 8'd0, 3'd2, 2'd1, 1, 0, "wr_beef", blat);
        axi_read(BASE + 32'h10, 4'd9, 8'd0, 3'd2, 2'd1, 0, "rd_beef", lat, d);
        chk("rd_beef_value", d, 32'hDEAD_BEEF);
`ifndef AXI_SLV_RAND_WAIT_EN
        chk("b_latency", 32'(blat), 32'd0);
        chk("r_latency", 32'(lat), 32'd1);
`endif

        wd[0] = 32'h1122_3344; ws[0] = 4'hF;
        axi_write(BASE + 32'h20, 4'd1, 8'd0, 3'd2, 2'd1, 1, 0, "wr_full", blat);
        wd[0] = 32'h00AB_0000; ws[0] = 4'b0100;
        axi_write(BASE + 32'h20, 4'd2, 8'd0, 3'd2, 2'd1, 1, 0, "wr_byte", blat);
        axi_read(BASE + 32'h20, 4'd3, 8'd0, 3'd2, 2'd1, 0, "rd_byte", lat, d);
        chk("rd_byte_value", d, 32'h11AB_3344);

        axi_read(BASE, 4'd4, 8'd3, 3'd2, 2'd1, 2, "rd_incr4", lat, d);

        axi_read(32'h7FFF_FFFC, 4'd6, 8'd0, 3'd2, 2'd1, 0, "rd_decerr", lat, d);
        chk("rd_decerr_zero", d, 32'h0);
        axi_read(BASE + 32'(4 * DEPTH), 4'd7, 8'd2, 3'd2, 2'd1, 0, "rd_decerr_top", lat, d);
        wd[0] = 32'h5A5A_5A5A; ws[0] = 4'hF;
        axi_write(BASE + 32'h40, 4'd6, 8'd0, 3'd3, 2'd1, 1, 0, "wr_slverr", blat);
        axi_read(BASE + 32'h40, 4'd6, 8'd0, 3'd2, 2'd1, 0, "rd_after_slverr", lat, d);

        wd[0] = 32'hFFFF_FFFF; ws[0] = 4'b0000;
        axi_write(BASE + 32'h44, 4'd8, 8'd0, 3'd2, 2'd1, 1, 0, "wr_nostrb", blat);
        axi_read(BASE + 32'h44, 4'd8, 8'd0, 3'd2, 2'd1, 0, "rd_nostrb", lat, d);

        for (int b = 0; b < 2; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
        axi_write(BASE + 32'h100, 4'd10, 8'd3, 3'd2, 2'd1, 2, 0, "wr_early_last", blat);
        axi_read(BASE + 32'h100, 4'd10, 8'd3, 3'd2, 2'd1, 0, "rd_early_last", lat, d);

        // Read and write presented together: read wins, write follows the read.
        @(negedge clk);
        bus.awvalid = 1; bus.awaddr = BASE + 32'h80; bus.awid = 4'd3; bus.awlen = 0;
        bus.awsize = 3'd2; bus.awburst = 2'd1;
        bus.wvalid = 1; bus.wdata = 32'hCAFE_F00D; bus.wstrb = 4'hF; bus.wlast = 1;
        bus.arvalid = 1; bus.araddr = BASE + 32'h10; bus.arid = 4'd7; bus.arlen = 0;
        bus.arsize = 3'd2; bus.arburst = 2'd1;
        #1;
        chk("prio_arready", 32'(bus.arready), 32'd1);
        chk("prio_awready", 32'(bus.awready), 32'd0);
        chk("prio_wready", 32'(bus.wready), 32'd0);
        @(negedge clk);
        bus.arvalid = 0;
        #1; n = 0;
        while (!bus.rvalid && n < 100) begin @(negedge clk); #1; n++; end
        chk("prio_rvalid", 32'(bus.rvalid), 32'd1);
        chk("prio_rdata", bus.rdata, model[4]);
        chk("prio_awready_during_read", 32'(bus.awready), 32'd0);
        bus.rready = 1;
        @(negedge clk);
        bus.rready = 0;
        #1; n = 0;
        while (!bus.awready && n < 100) begin @(negedge clk); #1; n++; end
        chk("prio_awready_after", 32'(bus.awready), 32'd1);
        @(negedge clk);
        bus.awvalid = 0; bus.wvalid = 0; bus.wlast = 0;
        #1; n = 0;
        while (!bus.bvalid && n < 100) begin @(negedge clk); #1; n++; end
        chk("prio_bresp", 32'(bus.bresp), 32'd0);
        chk("prio_bid", 32'(bus.bid), 32'd3);
        bus.bready = 1;
        @(negedge clk);
        bus.bready = 0;
        model[32] = 32'hCAFE_F00D;
        axi_read(BASE + 32'h80, 4'd2, 8'd0, 3'd2, 2'd1, 0, "prio_readback", lat, d);

        // Reset while an R beat is outstanding.
        @(negedge clk);
        bus.arvalid = 1; bus.araddr = BASE; bus.arid = 4'd5; bus.arlen = 8'd3;
        bus.arsize = 3'd2; bus.arburst = 2'd1;
        #1; n = 0;
        while (!bus.arready && n < 100) begin @(negedge clk); #1; n++; end
        @(negedge clk);
        bus.arvalid = 0;
        #1; n = 0;
        while (!bus.rvalid && n < 100) begin @(negedge clk); #1; n++; end
        chk("mid_rvalid", 32'(bus.rvalid), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_rvalid", 32'(bus.rvalid), 32'd0);
        chk("mid_rst_rlast", 32'(bus.rlast), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        axi_read(BASE + 32'h14, 4'd1, 8'd1, 3'd2, 2'd1, 0, "rd_after_rst", lat, d);

        for (int k = 0; k < 300; k++) begin
            sz  = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            bt  = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
            len = 8'($urandom_range(0, 7));
            a   = BASE + 32'($urandom_range(0, DEPTH - 1) * 4)
                + 32'($urandom_range(0, 3) & ((sz == 3'd0) ? 3 : ((sz == 3'd1) ? 2 : 0)));
            if ($urandom_range(0, 11) == 0)
                a = ($urandom_range(0, 1) == 1) ? BASE - 32'(4 * $urandom_range(1, 64))
                                                : BASE + 32'(4 * DEPTH + 4 * $urandom_range(0, 64));
            if ($urandom_range(0, 1) == 1) begin
                axi_read(a, 4'($urandom), len, sz, bt, 1, "rnd_rd", lat, d);
            end else begin
                for (int b = 0; b < 8; b++) begin wd[b] = $urandom; ws[b] = 4'($urandom); end
                nb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, int'(len) + 1)) : int'(len) + 1;
                axi_write(a, 4'($urandom), len, sz, bt, nb, 1, "rnd_wr", blat);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
